// File: rtl/AHB_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : AHB_pkg                                                           |
// | Brief   : AHB-Lite widths, signal encodings and byte-lane helper.           |
// | Rev     : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
package AHB_pkg;

    localparam int C_ADDR_WIDTH  = 32;
    localparam int C_DATA_WIDTH  = 32;
    localparam int C_TRANS_WIDTH = 2;
    localparam int C_SIZE_WIDTH  = 3;
    localparam int C_BURST_WIDTH = 3;
    localparam int C_PROT_WIDTH  = 4;
    localparam int C_RESP_WIDTH  = 1;
    localparam int C_READY_WIDTH = 1;

    typedef enum logic [C_TRANS_WIDTH-1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } HTRANS_e;

    typedef enum logic [C_SIZE_WIDTH-1:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } HSIZE_e;

    typedef enum logic [C_BURST_WIDTH-1:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } HBURST_e;

    typedef enum logic [C_RESP_WIDTH-1:0]  {HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1} HRESP_e;
    typedef enum logic [C_READY_WIDTH-1:0] {HREADY_WAIT = 1'b0, HREADY_DONE = 1'b1} HREADY_e;
    typedef enum logic {HWRITE_READ = 1'b0, HWRITE_WRITE = 1'b1} HWRITE_e;
    typedef enum logic {HSEL_OFF = 1'b0, HSEL_ON = 1'b1} HSEL_e;
    typedef enum logic {HRESET_RELEASE = 1'b0, HRESET_ASSERT = 1'b1} HRESET_e;

    // Little-endian lane enables for an already-validated size/offset pair.
    function automatic logic [3:0] ahb_byte_enables(input logic [C_SIZE_WIDTH-1:0] size,
                                                    input logic [1:0] off);
        case (size)
            HSIZE_BYTE: return 4'b0001 << off;
            HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : ahb_slave_ram                                                      |
// | Brief  : DEPTH x 32 word RAM, byte write enables, async read, sync clear.   |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module ahb_slave_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : ahb_lite_slave_mem                                                 |
// | Brief  : AHB-Lite memory slave, zero-wait OKAY, two-cycle ERROR response.   |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module ahb_lite_slave_mem
    import AHB_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic                     HWRITE,
    input  logic [C_TRANS_WIDTH-1:0] HTRANS,
    input  logic [C_SIZE_WIDTH-1:0]  HSIZE,
    input  logic [C_BURST_WIDTH-1:0] HBURST,
    input  logic [C_PROT_WIDTH-1:0]  HPROT,
    input  logic [ADDR_WIDTH-1:0]    HADDR,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic [C_RESP_WIDTH-1:0]  HRESP,
    output logic [C_READY_WIDTH-1:0] HREADY
);

    localparam int RAM_AW = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE_OK = 2'd0;
    localparam logic [1:0] ST_DATA_OK = 2'd1;
    localparam logic [1:0] ST_ERR1    = 2'd2;
    localparam logic [1:0] ST_ERR2    = 2'd3;

    // Despite the name, HRESETn is active-high here.
    logic w_rst;
    assign w_rst = HRESETn;

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;
    logic [RAM_AW-1:0] idx_q, idx_d;

    logic              w_sample, w_size_ok, w_align_ok, w_range_ok, w_legal;
    logic              w_ram_we;
    logic [31:0]       w_ram_rdata;
    logic              w_unused_sideband;

    assign w_unused_sideband = ^{HBURST, HPROT};

    assign w_sample   = HREADY[0] && HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign w_size_ok  = (HSIZE == HSIZE_BYTE) || (HSIZE == HSIZE_HALF) || (HSIZE == HSIZE_WORD);
    assign w_align_ok = (HSIZE == HSIZE_HALF) ? !HADDR[0] :
                        (HSIZE == HSIZE_WORD) ? (HADDR[1:0] == 2'b00) : 1'b1;
    assign w_range_ok = HADDR[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(MEM_DEPTH);
    assign w_legal    = w_size_ok && w_align_ok && w_range_ok;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            state_q <= ST_IDLE_OK;
            write_q <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
        end
    end

    // ERR2 drives HREADY high, so it samples a new address phase exactly like IDLE_OK.
    always_comb begin
        state_d = ST_IDLE_OK;
        write_d = write_q;
        be_d    = be_q;
        idx_d   = idx_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (w_sample) begin
            write_d = HWRITE;
            be_d    = ahb_byte_enables(HSIZE, HADDR[1:0]);
            idx_d   = HADDR[2 +: RAM_AW];
            state_d = w_legal ? ST_DATA_OK : ST_ERR1;
        end
    end

    always_comb begin
        HREADY = (state_q == ST_ERR1) ? HREADY_WAIT : HREADY_DONE;
        HRESP  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA = (state_q == ST_DATA_OK && !write_q) ? w_ram_rdata : '0;
    end

    assign w_ram_we = (state_q == ST_DATA_OK) && write_q;

    ahb_slave_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (w_rst),
        .we_i    (w_ram_we),
        .be_i    (be_q),
        .waddr_i (idx_q),
        .wdata_i (HWDATA),
        .raddr_i (idx_q),
        .rdata_o (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_ahb_lite_slave_mem                                              |
// | Brief  : Directed + random bus traffic against a transfer-level memory model|
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module tb_ahb_lite_slave_mem;

    localparam int M_IDLE = 0;
    localparam int M_RD   = 1;
    localparam int M_WR   = 2;
    localparam int M_E1   = 3;
    localparam int M_E2   = 4;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [0:0]  HRESP;
    logic [0:0]  HREADY;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: data phase currently on the bus plus a plain word array.
    int          ph;
    logic [31:0] p_addr;
    int          p_size;
    logic [31:0] mem [256];

    ahb_lite_slave_mem dut (
        .clk     (clk),
        .HRESETn (HRESETn),
        .HSEL    (HSEL),
        .HWRITE  (HWRITE),
        .HTRANS  (HTRANS),
        .HSIZE   (HSIZE),
        .HBURST  (HBURST),
        .HPROT   (HPROT),
        .HADDR   (HADDR),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HRESP   (HRESP),
        .HREADY  (HREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [31:0] exp_rdata;
        exp_rdata = (ph == M_RD) ? mem[p_addr / 4] : 32'h0;
        chk({where, "/hready"}, 32'(HREADY), (ph == M_E1) ? 32'd0 : 32'd1);
        chk({where, "/hresp"},  32'(HRESP),  (ph == M_E1 || ph == M_E2) ? 32'd1 : 32'd0);
        chk({where, "/hrdata"}, HRDATA, exp_rdata);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ph = M_IDLE;
    endtask

    task automatic do_reset(input int n, input bit first);
        @(negedge clk);
        if (!first) check_outputs("pre_rst");
        HRESETn = 1'b1;
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'd0; HSIZE = 3'd0; HADDR = 32'h0;
        model_clear();
        repeat (n) begin
            @(negedge clk);
            check_outputs("rst");
        end
        HRESETn = 1'b0;
    endtask

    // Check the data phase in progress, then drive the next address phase and
    // the write data belonging to the data phase in progress.
    task automatic bus_cycle(input string where, input bit sel, input bit wr,
                             input logic [1:0] trans, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int  b;
        bit  legal;
        @(negedge clk);
        check_outputs(where);
        HSEL = sel; HWRITE = wr; HTRANS = trans; HSIZE = size; HADDR = addr;
        HWDATA = wdata;
        HBURST = 3'($urandom); HPROT = 4'($urandom);
        if (ph == M_WR) begin
            for (int k = 0; k < (1 << p_size); k++) begin
                b = int'(p_addr % 4) + k;
                mem[p_addr / 4][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (ph == M_E1) begin
            ph = M_E2;
        end else if (sel && trans >= 2) begin
            legal  = (size <= 2) && (addr % (32'd1 << size) == 0) && (addr / 4 < 256);
            ph     = !legal ? M_E1 : (wr ? M_WR : M_RD);
            p_addr = addr;
            p_size = int'(size);
        end else begin
            ph = M_IDLE;
        end
    endtask

    task automatic idle(input string where, input logic [31:0] wdata);
        bus_cycle(where, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, wdata);
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  size;
        int          kind;
        HRESETn = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'd0; HSIZE = 3'd0;
        HBURST = 3'd0; HPROT = 4'd0; HADDR = 32'h0; HWDATA = 32'h0;
        ph = M_IDLE; p_addr = 32'h0; p_size = 0;

        do_reset(2, 1'b1);
        bus_cycle("rd0", 1, 0, 2'd2, 3'd2, 32'h0, 32'h0);
        idle("rd0_data", 32'h0);

        bus_cycle("wr10", 1, 1, 2'd2, 3'd2, 32'h10, 32'h0);
        bus_cycle("rd10", 1, 0, 2'd3, 3'd2, 32'h10, 32'hDEADBEEF);
        idle("rd10_data", 32'h0);

        bus_cycle("wr10b", 1, 1, 2'd2, 3'd2, 32'h10, 32'h0);
        bus_cycle("wr13", 1, 1, 2'd2, 3'd0, 32'h13, 32'h11223344);
        bus_cycle("rd10c", 1, 0, 2'd2, 3'd2, 32'h10, 32'hAAAAAAAA);
        bus_cycle("wr12", 1, 1, 2'd2, 3'd1, 32'h12, 32'h0);
        bus_cycle("rd10d", 1, 0, 2'd2, 3'd2, 32'h10, 32'hBEEFBEEF);
        idle("rd10d_data", 32'h0);

        bus_cycle("mis02", 1, 0, 2'd2, 3'd2, 32'h02, 32'h0);
        idle("mis_e1", 32'h0);
        idle("mis_e2", 32'h0);
        bus_cycle("oor400", 1, 1, 2'd2, 3'd2, 32'h400, 32'h0);
        bus_cycle("ignored", 1, 1, 2'd2, 3'd2, 32'h10, 32'h0);
        bus_cycle("sz3", 1, 1, 2'd2, 3'd3, 32'h10, 32'h0);
        idle("sz3_e1", 32'h12345678);
        bus_cycle("rd10e", 1, 0, 2'd2, 3'd2, 32'h10, 32'h0);

        bus_cycle("idle_wr", 1, 1, 2'd0, 3'd2, 32'h10, 32'h0);
        bus_cycle("busy_wr", 1, 1, 2'd1, 3'd2, 32'h10, 32'h55555555);
        bus_cycle("nosel_wr", 0, 1, 2'd2, 3'd2, 32'h10, 32'h66666666);
        bus_cycle("rd10f", 1, 0, 2'd2, 3'd2, 32'h10, 32'h77777777);
        bus_cycle("err_again", 1, 0, 2'd2, 3'd1, 32'h11, 32'h0);
        idle("err_e1", 32'h0);
        do_reset(1, 1'b0);
        bus_cycle("rd10g", 1, 0, 2'd2, 3'd2, 32'h10, 32'h0);
        idle("rd10g_data", 32'h0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset(1, 1'b0);
            kind = int'($urandom_range(0, 9));
            size = (kind == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 15)) * 4;
            if (kind == 1)      addr = addr + 32'($urandom_range(0, 3));
            else if (kind == 2) addr = $urandom | 32'h400;
            else if (size == 3'd0) addr = addr + 32'($urandom_range(0, 3));
            else if (size == 3'd1) addr = addr + 32'($urandom_range(0, 1)) * 2;
            bus_cycle("rand", $urandom_range(0, 7) != 0, 1'($urandom),
                      2'($urandom), size, addr, $urandom);
        end
        idle("tail", 32'h0);
        idle("tail", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
